// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: S-box tables, FSM encoding and the bitsliced S-box helper.
package serpent_pkg;

   localparam int ROUNDS     = 32;
   localparam int FINAL_KIDX = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // 32-bit rotate left by a constant amount (1..31).
   function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // One Serpent S-box lookup; each table row lists entries 0..15 from the MSB down.
   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [3:0] x);
      logic [63:0] row;
      case (box)
         3'd0:    row = 64'h38F1A65BED42709C;
         3'd1:    row = 64'hFC27905A1BE86D34;
         3'd2:    row = 64'h86793CAFD1E40B52;
         3'd3:    row = 64'h0FB8C963D124A75E;
         3'd4:    row = 64'h1F83C0B6254A9E7D;
         3'd5:    row = 64'hF52B4A9C03E8D671;
         3'd6:    row = 64'h72C5846BE91FD3A0;
         default: row = 64'h1DF0E82B74CA9356;
      endcase
      return row[(6'd60 - {x, 2'b00}) +: 4];
   endfunction

   // Bitsliced S-box: bit i of X0..X3 forms nibble {X3,X2,X1,X0}, result written back in place.
   function automatic logic [127:0] sbox_apply(input logic [2:0] box, input logic [127:0] blk);
      logic [31:0] x0, x1, x2, x3;
      logic [31:0] y0, y1, y2, y3;
      logic [3:0]  s;
      x0 = blk[127:96];
      x1 = blk[95:64];
      x2 = blk[63:32];
      x3 = blk[31:0];
      y0 = '0;
      y1 = '0;
      y2 = '0;
      y3 = '0;
      for (int i = 0; i < 32; i++) begin
         s     = sbox_lookup(box, {x3[i], x2[i], x1[i], x0[i]});
         y0[i] = s[0];
         y1[i] = s[1];
         y2[i] = s[2];
         y3[i] = s[3];
      end
      return {y0, y1, y2, y3};
   endfunction

endpackage

// File: rtl/serpent_lt.sv
// Serpent linear transform on four 32-bit words, X0 in the top word.
module serpent_lt
   import serpent_pkg::*;
(
   input  logic [127:0] i_data,
   output logic [127:0] o_data
);

   logic [31:0] x0, x1, x2, x3;

   // Rotate/xor mixing network, evaluated in the standard step order.
   always_comb begin
      x0 = i_data[127:96];
      x1 = i_data[95:64];
      x2 = i_data[63:32];
      x3 = i_data[31:0];
      x0 = rotl32(x0, 13);
      x2 = rotl32(x2, 3);
      x1 = x1 ^ x0 ^ x2;
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = rotl32(x1, 1);
      x3 = rotl32(x3, 7);
      x0 = x0 ^ x1 ^ x3;
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = rotl32(x0, 5);
      x2 = rotl32(x2, 22);
      o_data = {x0, x1, x2, x3};
   end

endmodule

// File: rtl/serpent_sbox_layer.sv
// Combinational bitsliced S-box layer over a full 128-bit block.
module serpent_sbox_layer
   import serpent_pkg::*;
(
   input  logic [127:0] i_data,
   input  logic [2:0]   i_sel,
   output logic [127:0] o_data
);

   // Apply the selected S-box to all 32 bit columns.
   always_comb begin
      o_data = sbox_apply(i_sel, i_data);
   end

endmodule

// File: rtl/serpent_round_sched.sv
// Iterative Serpent-128 encryptor: one round per cycle on a shared datapath,
// round keys fetched by index from an external same-cycle key store.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. o_ready is high only in IDLE; o_valid/o_data are held stable in DONE until
// i_ready is seen, and the producer side never withdraws a valid it has raised.
module serpent_round_sched
   import serpent_pkg::*;
#(
   parameter int KIDX_W = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [127:0]      i_data,
   output logic [KIDX_W-1:0] o_rkey_idx,
   input  logic [127:0]      i_rkey,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [127:0]      o_data,
   output logic              o_busy,
   output logic [1:0]        o_state
);

   state_t            state;
   logic [KIDX_W-1:0] rnd;
   logic [127:0]      blk;
   logic [127:0]      mixed;
   logic [127:0]      sbox_out;
   logic [127:0]      lt_out;

   // Key mix feeds both the S-box layer and the final whitening step.
   always_comb begin
      mixed = blk ^ i_rkey;
   end

   serpent_sbox_layer u_sbox (
      .i_data (mixed),
      .i_sel  (rnd[2:0]),
      .o_data (sbox_out)
   );

   serpent_lt u_lt (
      .i_data (sbox_out),
      .o_data (lt_out)
   );

   // Key index follows the round counter; the final whitening key sits after the last round.
   always_comb begin
      case (state)
         ST_ROUND: o_rkey_idx = rnd;
         ST_FINAL: o_rkey_idx = KIDX_W'(FINAL_KIDX);
         default:  o_rkey_idx = '0;
      endcase
   end

   // Status outputs decode straight from the state register.
   always_comb begin
      o_ready = (state == ST_IDLE);
      o_valid = (state == ST_DONE);
      o_busy  = (state == ST_ROUND) || (state == ST_FINAL);
      o_state = state;
      o_data  = blk;
   end

   // Control FSM, round counter and block register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         rnd   <= '0;
         blk   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  blk   <= i_data;
                  rnd   <= '0;
                  state <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               // The last round skips the linear transform.
               if (rnd == KIDX_W'(ROUNDS - 1)) begin
                  blk   <= sbox_out;
                  rnd   <= KIDX_W'(ROUNDS);
                  state <= ST_FINAL;
               end else begin
                  blk <= lt_out;
                  rnd <= rnd + KIDX_W'(1);
               end
            end
            ST_FINAL: begin
               blk   <= mixed;
               state <= ST_DONE;
            end
            default: begin
               if (i_ready) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serpent_round_sched.sv
// Directed bench for serpent_round_sched with a reference Serpent model,
// a behavioural key store and an expected-ciphertext queue.
module tb_serpent_round_sched;
   import serpent_pkg::*;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic [5:0]   o_rkey_idx;
   logic [127:0] i_rkey;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;
   logic         o_busy;
   logic [1:0]   o_state;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   logic [127:0] exp_q[$];
   logic [127:0] rk_mem [0:63];
   logic [31:0]  pw [0:139];
   logic [127:0] stream_data [4];
   int           acc_cyc [4];

   localparam logic [127:0] PT_ZERO = 128'h0;
   localparam logic [127:0] PT_KAT  = 128'h0123456789ABCDEFFEDCBA9876543210;

   int sbox_tab [8][16] = '{
      '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
      '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
      '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
      '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
      '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
      '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
      '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
      '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
   };

   serpent_round_sched #(.KIDX_W(6)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
      .o_rkey_idx (o_rkey_idx),
      .i_rkey     (i_rkey),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_busy     (o_busy),
      .o_state    (o_state)
   );

   // Clock and cycle counter.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Key-schedule store: same-cycle read by index.
   assign i_rkey = rk_mem[o_rkey_idx];

   // ---------------- reference model ----------------
   function automatic logic [31:0] trol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] m_sbox(input int box, input logic [127:0] b);
      logic [31:0] w [4];
      logic [31:0] o [4];
      int idx;
      int v;
      w[0] = b[127:96]; w[1] = b[95:64]; w[2] = b[63:32]; w[3] = b[31:0];
      for (int j = 0; j < 4; j++) o[j] = '0;
      for (int i = 0; i < 32; i++) begin
         idx = 0;
         for (int j = 0; j < 4; j++) if (w[j][i]) idx += (1 << j);
         v = sbox_tab[box][idx];
         for (int j = 0; j < 4; j++) o[j][i] = ((v >> j) & 1) != 0;
      end
      return {o[0], o[1], o[2], o[3]};
   endfunction

   function automatic logic [127:0] m_lt(input logic [127:0] b);
      logic [31:0] a0, a1, a2, a3;
      a0 = b[127:96]; a1 = b[95:64]; a2 = b[63:32]; a3 = b[31:0];
      a0 = trol(a0, 13);
      a2 = trol(a2, 3);
      a1 = a1 ^ a0 ^ a2;
      a3 = a3 ^ a2 ^ (a0 << 3);
      a1 = trol(a1, 1);
      a3 = trol(a3, 7);
      a0 = a0 ^ a1 ^ a3;
      a2 = a2 ^ a3 ^ (a1 << 7);
      a0 = trol(a0, 5);
      a2 = trol(a2, 22);
      return {a0, a1, a2, a3};
   endfunction

   function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
      logic [127:0] b;
      b = pt;
      for (int r = 0; r < 32; r++) begin
         b = m_sbox(r % 8, b ^ rk_mem[r]);
         if (r < 31) b = m_lt(b);
      end
      return b ^ rk_mem[32];
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      n_checks++;
      assert (exp_q.size() != 0)
      else begin
         n_fail++;
         $error("FAIL %s_queue_empty observed=%h expected=queued_value", tag, o_data);
      end
      if (exp_q.size() != 0) check(tag, o_data, exp_q.pop_front());
   endtask

   task automatic send_block(input logic [127:0] pt, input bit expect_out);
      check("accept_ready", 128'(o_ready), 128'd1);
      i_valid = 1'b1;
      i_data  = pt;
      if (expect_out) exp_q.push_back(m_encrypt(pt));
      tick();
      i_valid = 1'b0;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_valid(input int limit);
      int n;
      n = 0;
      while (!o_valid && n < limit) begin
         tick();
         n++;
      end
      check("valid_timeout", 128'(o_valid), 128'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 128'(o_ready), 128'd1);
      check({tag, "_valid"}, 128'(o_valid), 128'd0);
      check({tag, "_busy"},  128'(o_busy),  128'd0);
      check({tag, "_kidx"},  128'(o_rkey_idx), 128'd0);
      check({tag, "_data"},  o_data, 128'd0);
   endtask

   // Hard stop if the sequence ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int blocks_sent;
      int blocks_done;
      int guard;

      // Key schedule for an all-zero 128-bit key (padded with a single 1 bit).
      for (int i = 0; i < 8; i++) pw[i] = '0;
      pw[4] = 32'h1;
      for (int i = 8; i < 140; i++)
         pw[i] = trol(pw[i-8] ^ pw[i-5] ^ pw[i-3] ^ pw[i-1] ^ 32'h9E3779B9 ^ 32'(i - 8), 11);
      for (int k = 0; k < 33; k++)
         rk_mem[k] = m_sbox((35 - k) % 8, {pw[8+4*k], pw[9+4*k], pw[10+4*k], pw[11+4*k]});
      for (int k = 33; k < 64; k++)
         rk_mem[k] = {$urandom, $urandom, $urandom, $urandom};

      // Reset with random inputs.
      i_rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_ready = 1'($urandom_range(0, 1));
         i_data  = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      check_reset_outputs("reset");
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_rst_n = 1'b1;
      tick();

      // Key-index sequence and latency with an all-zero block.
      send_block(PT_ZERO, 1'b1);
      for (int k = 0; k <= 32; k++) begin
         check("rkey_idx", 128'(o_rkey_idx), 128'(k));
         check("valid_early", 128'(o_valid), 128'd0);
         tick();
      end
      check("valid_at_t0_plus_33", 128'(o_valid), 128'd1);
      check("kidx_done", 128'(o_rkey_idx), 128'd0);
      i_ready = 1'b1;
      pop_check("kat_zero");
      tick();
      i_ready = 1'b0;
      check("idle_after_zero", 128'(o_state), 128'(ST_IDLE));

      // Second known answer under backpressure.
      send_block(PT_KAT, 1'b1);
      wait_valid(40);
      for (int i = 0; i < 10; i++) begin
         i_valid = 1'b1;
         i_data  = {$urandom, $urandom, $urandom, $urandom};
         check("hold_valid", 128'(o_valid), 128'd1);
         check("hold_data",  o_data, exp_q[0]);
         check("hold_ready", 128'(o_ready), 128'd0);
         tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      pop_check("kat_0123");
      tick();
      i_ready = 1'b0;
      check("idle_after_bp", 128'(o_state), 128'(ST_IDLE));
      check("ready_after_bp", 128'(o_ready), 128'd1);
      tick();
      check("ignored_valid_no_start", 128'(o_busy), 128'd0);

      // Reset asserted during round 17, then a clean block.
      send_block(PT_ZERO, 1'b0);
      n = 0;
      while (o_rkey_idx != 6'd17 && n < 40) begin
         tick();
         n++;
      end
      check("round17_reached", 128'(o_rkey_idx), 128'd17);
      #3;
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      tick();
      check_reset_outputs("after_midreset");
      send_block(PT_KAT, 1'b1);
      wait_valid(40);
      i_ready = 1'b1;
      pop_check("kat_after_reset");
      tick();
      i_ready = 1'b0;

      // Streaming: valid and ready held high across four blocks.
      for (int b = 0; b < 4; b++) stream_data[b] = {$urandom, $urandom, $urandom, $urandom};
      stream_data[0] = PT_ZERO;
      blocks_sent = 0;
      blocks_done = 0;
      guard       = 0;
      i_valid     = 1'b1;
      i_ready     = 1'b1;
      while (blocks_done < 4 && guard < 400) begin
         if (blocks_sent == 4 && !o_ready) i_valid = 1'b0;
         if (o_ready && blocks_sent < 4) begin
            i_data = stream_data[blocks_sent];
            exp_q.push_back(m_encrypt(stream_data[blocks_sent]));
            acc_cyc[blocks_sent] = cyc + 1;
            blocks_sent++;
         end
         if (o_valid) begin
            pop_check("stream_ct");
            blocks_done++;
         end
         tick();
         guard++;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      check("stream_blocks_done", 128'(blocks_done), 128'd4);
      for (int b = 1; b < 4; b++)
         check("stream_spacing", 128'(acc_cyc[b] - acc_cyc[b-1]), 128'd35);
      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
